// File: rtl/sum_accum_pkg.sv
// Shared types for the registered sum/accumulate unit: operating modes and
// the width-legality rule between operand and accumulator widths.
package sum_accum_pkg;

  typedef enum logic [1:0] {
    MODE_ADD    = 2'd0,
    MODE_SATADD = 2'd1,
    MODE_SUB    = 2'd2,
    MODE_ACC    = 2'd3
  } mode_e;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_ACC_WIDTH = 16;

  // The accumulator must hold at least one full a+b sum including its carry.
  function automatic bit widths_ok(input int w, input int aw);
    return (aw > w) && (w > 0);
  endfunction

  localparam bit DEF_WIDTHS_OK = widths_ok(DEF_WIDTH, DEF_ACC_WIDTH);

endpackage

// File: rtl/sum_accum_core.sv
// Stateless datapath: produces {result, flag} for one beat from the operands,
// the mode and the accumulator base (already cleared by the caller if needed).
module sum_accum_core
  import sum_accum_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  mode_e                mode_i,
  input  logic [ACC_WIDTH-1:0] base_i,
  output logic [ACC_WIDTH-1:0] result_o,
  output logic                 flag_o
);

  localparam int PAD = ACC_WIDTH + 1 - WIDTH;
  localparam int ZX  = ACC_WIDTH - WIDTH;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [ACC_WIDTH:0] acc_sum;

  assign sum     = {1'b0, a_i} + {1'b0, b_i};
  // The extra top bit of the difference is the borrow (set when a < b).
  assign diff    = {1'b0, a_i} - {1'b0, b_i};
  assign acc_sum = {1'b0, base_i} + {{PAD{1'b0}}, a_i} + {{PAD{1'b0}}, b_i};

  always_comb begin
    result_o = '0;
    flag_o   = 1'b0;
    unique case (mode_i)
      MODE_ADD: begin
        result_o = {{ZX{1'b0}}, sum[WIDTH-1:0]};
        flag_o   = sum[WIDTH];
      end
      MODE_SATADD: begin
        result_o = sum[WIDTH] ? {{ZX{1'b0}}, {WIDTH{1'b1}}}
                              : {{ZX{1'b0}}, sum[WIDTH-1:0]};
        flag_o   = sum[WIDTH];
      end
      MODE_SUB: begin
        result_o = {{ZX{1'b0}}, diff[WIDTH-1:0]};
        flag_o   = diff[WIDTH];
      end
      MODE_ACC: begin
        result_o = acc_sum[ACC_WIDTH-1:0];
        flag_o   = acc_sum[ACC_WIDTH];
      end
      default: begin
        result_o = '0;
        flag_o   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sum_accum_unit.sv
// Registered add/satadd/sub/accumulate unit with a valid/ready handshake,
// a one-entry output register and a sticky accumulator-overflow flag.
module sum_accum_unit
  import sum_accum_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [1:0]           in_mode,
  input  logic                 acc_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_result,
  output logic                 out_flag,
  output logic                 acc_ovf
);

  if (!widths_ok(WIDTH, ACC_WIDTH)) begin : g_bad_widths
    $error("sum_accum_unit: ACC_WIDTH must exceed WIDTH");
  end

  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] out_result_q, out_result_d;
  logic                 out_flag_q, out_flag_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 acc_ovf_q, acc_ovf_d;

  logic                 accept;
  logic                 xfer;
  mode_e                mode;
  logic [ACC_WIDTH-1:0] base;
  logic [ACC_WIDTH-1:0] core_result;
  logic                 core_flag;

  assign mode     = mode_e'(in_mode);
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid_q && out_ready;
  // Clear is applied before the add so a clearing ACC beat starts from zero.
  assign base     = acc_clr ? '0 : acc_q;

  sum_accum_core #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_core (
    .a_i      (in_a),
    .b_i      (in_b),
    .mode_i   (mode),
    .base_i   (base),
    .result_o (core_result),
    .flag_o   (core_flag)
  );

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_flag_d   = out_flag_q;
    acc_d        = acc_q;
    acc_ovf_d    = acc_ovf_q;

    if (accept) begin
      out_valid_d  = 1'b1;
      out_result_d = core_result;
      out_flag_d   = core_flag;
    end else if (xfer) begin
      out_valid_d  = 1'b0;
    end

    if (accept && mode == MODE_ACC) begin
      acc_d     = core_result;
      acc_ovf_d = (acc_clr ? 1'b0 : acc_ovf_q) | core_flag;
    end else if (acc_clr) begin
      acc_d     = '0;
      acc_ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flag_q   <= 1'b0;
      acc_q        <= '0;
      acc_ovf_q    <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_flag_q   <= out_flag_d;
      acc_q        <= acc_d;
      acc_ovf_q    <= acc_ovf_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_flag   = out_flag_q;
  assign acc_ovf    = acc_ovf_q;

endmodule

// File: tb/tb_sum_accum_unit.sv
// Directed bench for sum_accum_unit (WIDTH=8, ACC_WIDTH=16) with hand-computed expectations.
module tb_sum_accum_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [1:0]  in_mode;
  logic        acc_clr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_flag;
  logic        acc_ovf;

  int total = 0;
  int bad   = 0;

  sum_accum_unit #(.WIDTH(8), .ACC_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_mode    (in_mode),
    .acc_clr    (acc_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flag   (out_flag),
    .acc_ovf    (acc_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                      input logic clr);
    in_valid = 1'b1;
    in_mode  = m;
    in_a     = a;
    in_b     = b;
    acc_clr  = clr;
    step();
    in_valid = 1'b0;
    acc_clr  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0;
    acc_clr = 1'b0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_valid",  32'(out_valid), 0);
    chk("rst_result", 32'(out_result), 0);
    chk("rst_ovf",    32'(acc_ovf), 0);
    chk("rst_ready",  32'(in_ready), 1);

    send(2'd0, 8'd200, 8'd100, 1'b0);
    chk("add_valid", 32'(out_valid), 1);
    chk("add_res",   32'(out_result), 44);
    chk("add_flag",  32'(out_flag), 1);
    send(2'd1, 8'd200, 8'd100, 1'b0);
    chk("sat_res",  32'(out_result), 255);
    chk("sat_flag", 32'(out_flag), 1);
    send(2'd1, 8'd10, 8'd20, 1'b0);
    chk("sat2_res",  32'(out_result), 30);
    chk("sat2_flag", 32'(out_flag), 0);
    send(2'd2, 8'd5, 8'd7, 1'b0);
    chk("sub_res",  32'(out_result), 254);
    chk("sub_flag", 32'(out_flag), 1);
    send(2'd2, 8'd7, 8'd5, 1'b0);
    chk("sub2_res",  32'(out_result), 2);
    chk("sub2_flag", 32'(out_flag), 0);
    chk("nonacc_ovf", 32'(acc_ovf), 0);

    // Accumulator still zero: non-ACC beats leave it untouched.
    for (int i = 0; i < 10; i++) send(2'd3, 8'd255, 8'd255, 1'b0);
    chk("acc10_res", 32'(out_result), 5100);
    chk("acc10_ovf", 32'(acc_ovf), 0);
    send(2'd3, 8'd1, 8'd2, 1'b1);
    chk("accclr_res", 32'(out_result), 3);

    // Back-pressure
    out_ready = 1'b0;
    send(2'd0, 8'd1, 8'd2, 1'b0);
    chk("bp_valid", 32'(out_valid), 1);
    in_valid = 1'b1; in_mode = 2'd0; in_a = 8'd50; in_b = 8'd50;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", 32'(in_ready), 0);
      step();
      chk("bp_hold", 32'(out_result), 3);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready_up", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk("bp_new_res",   32'(out_result), 100);
    chk("bp_new_valid", 32'(out_valid), 1);
    step();
    chk("bp_drain", 32'(out_valid), 0);

    // Wrap: 128*510 + 255 = 65535, then +1 wraps to zero with carry.
    send(2'd3, 8'd255, 8'd255, 1'b1);
    for (int i = 0; i < 127; i++) send(2'd3, 8'd255, 8'd255, 1'b0);
    send(2'd3, 8'd255, 8'd0, 1'b0);
    chk("pre_res",  32'(out_result), 65535);
    chk("pre_flag", 32'(out_flag), 0);
    send(2'd3, 8'd1, 8'd0, 1'b0);
    chk("wrap_res",  32'(out_result), 0);
    chk("wrap_flag", 32'(out_flag), 1);
    chk("wrap_ovf",  32'(acc_ovf), 1);
    send(2'd0, 8'd1, 8'd1, 1'b0);
    chk("sticky_res", 32'(out_result), 2);
    chk("sticky_ovf", 32'(acc_ovf), 1);
    step();
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    chk("clr_ovf",    32'(acc_ovf), 0);
    chk("clr_keep",   32'(out_result), 2);
    chk("clr_keep_v", 32'(out_valid), 0);
    send(2'd3, 8'd4, 8'd5, 1'b0);
    chk("clr_acc", 32'(out_result), 9);

    // Asynchronous reset with a pending, stalled result.
    out_ready = 1'b0;
    send(2'd3, 8'd10, 8'd10, 1'b0);
    chk("pend_valid", 32'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk("arst_valid",  32'(out_valid), 0);
    chk("arst_result", 32'(out_result), 0);
    chk("arst_ovf",    32'(acc_ovf), 0);
    chk("arst_ready",  32'(in_ready), 1);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    send(2'd3, 8'd1, 8'd1, 1'b0);
    chk("arst_acc", 32'(out_result), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
